// File: rtl/ifid_pipe_reg_pkg.sv
// Shared IF/ID definitions: default widths, field positions, FSM states and bundle layout.
package ifid_pipe_reg_pkg;

  localparam int IFID_LANES         = 2;
  localparam int IFID_ADDR_WIDTH    = 32;
  localparam int IFID_INSN_WIDTH    = 32;
  localparam int IFID_REG_NUM_WIDTH = 5;
  localparam int IFID_RS_POS        = 21;
  localparam int IFID_RT_POS        = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FULL  = 2'd2
  } ifidState_e;

  // Bundle layout at the default configuration; the top rebuilds the same shape from its parameters.
  typedef struct packed {
    logic                                          valid;
    logic [IFID_LANES-1:0]                         laneValid;
    logic [IFID_LANES-1:0][IFID_ADDR_WIDTH-1:0]    pc;
    logic [IFID_LANES-1:0][IFID_INSN_WIDTH-1:0]    insn;
  } ifidBundle_t;

  function automatic logic [31:0] satInc32(input logic [31:0] value);
    if (value == 32'hFFFF_FFFF) begin
      return value;
    end else begin
      return value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/ifid_pipe_reg_bundle_reg.sv
// Loadable/clearable bundle register; used for both the main and the skid entry of the IF/ID stage.
module ifid_bundle_reg #(
  parameter type bundle_t = logic [0:0]
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clear,
  input  logic    load,
  input  bundle_t d,
  output bundle_t q
);

  // Clearing zeroes the whole entry so an invalid bundle never exposes stale payload.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= bundle_t'(1'b0);
    end else if (clear) begin
      q <= bundle_t'(1'b0);
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with ready/valid handshake and one-entry skid buffer.
// Optional macro IFID_PERF_COUNTER_EN adds saturating stall/flush event counters.
module ifid_pipe_reg
  import ifid_pipe_reg_pkg::*;
#(
  parameter int LANES         = IFID_LANES,
  parameter int ADDR_WIDTH    = IFID_ADDR_WIDTH,
  parameter int INSN_WIDTH    = IFID_INSN_WIDTH,
  parameter int REG_NUM_WIDTH = IFID_REG_NUM_WIDTH,
  parameter int RS_POS        = IFID_RS_POS,
  parameter int RT_POS        = IFID_RT_POS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             stall,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0]                 in_lane_valid,
  input  logic [LANES*ADDR_WIDTH-1:0]      in_pc,
  input  logic [LANES*INSN_WIDTH-1:0]      in_insn,
  output logic                             out_valid,
  output logic [LANES-1:0]                 out_lane_valid,
  output logic [LANES*ADDR_WIDTH-1:0]      out_pc,
  output logic [LANES*INSN_WIDTH-1:0]      out_insn,
  output logic [LANES*REG_NUM_WIDTH-1:0]   out_rs,
  output logic [LANES*REG_NUM_WIDTH-1:0]   out_rt,
  output logic [31:0]                      perf_stall_cnt,
  output logic [31:0]                      perf_flush_cnt
);

  typedef struct packed {
    logic                                valid;
    logic [LANES-1:0]                    laneValid;
    logic [LANES-1:0][ADDR_WIDTH-1:0]    pc;
    logic [LANES-1:0][INSN_WIDTH-1:0]    insn;
  } bundle_t;

  ifidState_e stateQ_r;
  ifidState_e stateNext_s;
  logic       inReady_r;
  logic       accept_s;
  logic       mainLoad_s;
  logic       mainClear_s;
  logic       skidLoad_s;
  logic       skidClear_s;
  bundle_t    inBundle_s;
  bundle_t    mainD_s;
  bundle_t    mainQ_s;
  bundle_t    skidQ_s;

  assign accept_s             = in_valid && inReady_r;
  assign inBundle_s.valid     = in_valid;
  assign inBundle_s.laneValid = in_lane_valid;
  assign inBundle_s.pc        = in_pc;
  assign inBundle_s.insn      = in_insn;

  // Next-state and storage control; flush overrides stall, stall overrides advance.
  always_comb begin
    stateNext_s = stateQ_r;
    mainLoad_s  = 1'b0;
    mainClear_s = 1'b0;
    skidLoad_s  = 1'b0;
    skidClear_s = 1'b0;
    mainD_s     = inBundle_s;
    if (flush) begin
      mainClear_s = 1'b1;
      skidClear_s = 1'b1;
      stateNext_s = ST_EMPTY;
    end else begin
      case (stateQ_r)
        ST_EMPTY: begin
          // An empty main slot can always take a bundle, stalled or not.
          if (accept_s) begin
            mainLoad_s  = 1'b1;
            stateNext_s = ST_HOLD;
          end else begin
            stateNext_s = ST_EMPTY;
          end
        end
        ST_HOLD: begin
          if (stall) begin
            if (accept_s) begin
              skidLoad_s  = 1'b1;
              stateNext_s = ST_FULL;
            end else begin
              stateNext_s = ST_HOLD;
            end
          end else if (accept_s) begin
            mainLoad_s  = 1'b1;
            stateNext_s = ST_HOLD;
          end else begin
            mainClear_s = 1'b1;
            stateNext_s = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (stall) begin
            stateNext_s = ST_FULL;
          end else begin
            mainD_s     = skidQ_s;
            mainLoad_s  = 1'b1;
            skidClear_s = 1'b1;
            stateNext_s = ST_HOLD;
          end
        end
        default: begin
          mainClear_s = 1'b1;
          skidClear_s = 1'b1;
          stateNext_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; in_ready is precomputed so it is a flop output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ_r  <= ST_EMPTY;
      inReady_r <= 1'b1;
    end else begin
      stateQ_r  <= stateNext_s;
      inReady_r <= (stateNext_s != ST_FULL);
    end
  end

  ifid_bundle_reg #(.bundle_t(bundle_t)) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (mainClear_s),
    .load  (mainLoad_s),
    .d     (mainD_s),
    .q     (mainQ_s)
  );

  ifid_bundle_reg #(.bundle_t(bundle_t)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (skidClear_s),
    .load  (skidLoad_s),
    .d     (inBundle_s),
    .q     (skidQ_s)
  );

  // Main is zeroed whenever it is invalid, so outputs come straight from the flops.
  assign in_ready       = inReady_r;
  assign out_valid      = mainQ_s.valid;
  assign out_lane_valid = mainQ_s.laneValid;
  assign out_pc         = mainQ_s.pc;
  assign out_insn       = mainQ_s.insn;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [INSN_WIDTH-1:0] laneInsn_s;
    assign laneInsn_s = mainQ_s.insn[l];
    assign out_rs[l*REG_NUM_WIDTH +: REG_NUM_WIDTH] = mainQ_s.laneValid[l] ?
        laneInsn_s[RS_POS +: REG_NUM_WIDTH] : {REG_NUM_WIDTH{1'b0}};
    assign out_rt[l*REG_NUM_WIDTH +: REG_NUM_WIDTH] = mainQ_s.laneValid[l] ?
        laneInsn_s[RT_POS +: REG_NUM_WIDTH] : {REG_NUM_WIDTH{1'b0}};
  end

`ifdef IFID_PERF_COUNTER_EN
  logic [31:0] perfStallCnt_r;
  logic [31:0] perfFlushCnt_r;

  // Saturating event counters: stalled cycles with a live bundle, and flush cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perfStallCnt_r <= 32'd0;
      perfFlushCnt_r <= 32'd0;
    end else begin
      if (stall && mainQ_s.valid && !flush) begin
        perfStallCnt_r <= satInc32(perfStallCnt_r);
      end else begin
        perfStallCnt_r <= perfStallCnt_r;
      end
      if (flush) begin
        perfFlushCnt_r <= satInc32(perfFlushCnt_r);
      end else begin
        perfFlushCnt_r <= perfFlushCnt_r;
      end
    end
  end

  assign perf_stall_cnt = perfStallCnt_r;
  assign perf_flush_cnt = perfFlushCnt_r;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Scoreboard bench for ifid_pipe_reg: directed bundles, expected fields hand-computed per vector.
module tb_ifid_pipe_reg;

  localparam int L  = 2;
  localparam int AW = 32;
  localparam int IW = 32;
  localparam int RW = 5;

  typedef struct {
    logic [L-1:0]    lv;
    logic [L*AW-1:0] pc;
    logic [L*IW-1:0] insn;
    logic [L*RW-1:0] rs;
    logic [L*RW-1:0] rt;
  } vec_t;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            stall;
  logic            in_valid;
  logic            in_ready;
  logic [L-1:0]    in_lane_valid;
  logic [L*AW-1:0] in_pc;
  logic [L*IW-1:0] in_insn;
  logic            out_valid;
  logic [L-1:0]    out_lane_valid;
  logic [L*AW-1:0] out_pc;
  logic [L*IW-1:0] out_insn;
  logic [L*RW-1:0] out_rs;
  logic [L*RW-1:0] out_rt;
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_flush_cnt;

  vec_t vecs [7];
  vec_t expQ [$];
  int   curIdx;
  logic monOn;
  int   errors;
  int   checks;

  ifid_pipe_reg dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall          (stall),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_lane_valid  (in_lane_valid),
    .in_pc          (in_pc),
    .in_insn        (in_insn),
    .out_valid      (out_valid),
    .out_lane_valid (out_lane_valid),
    .out_pc         (out_pc),
    .out_insn       (out_insn),
    .out_rs         (out_rs),
    .out_rt         (out_rt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor/scoreboard: a bundle is consumed when valid and decode is not stalled or flushed.
  always @(negedge clk) begin
    if (monOn && rst) begin
      if (out_valid && !stall && !flush) begin
        if (expQ.size() == 0) begin
          check("unexpected_bundle", {96'd0, out_pc[31:0]}, 128'd0);
        end else begin
          vec_t e;
          e = expQ.pop_front();
          check("out_lane_valid", {126'd0, out_lane_valid}, {126'd0, e.lv});
          check("out_pc", {64'd0, out_pc}, {64'd0, e.pc});
          check("out_insn", {64'd0, out_insn}, {64'd0, e.insn});
          check("out_rs", {118'd0, out_rs}, {118'd0, e.rs});
          check("out_rt", {118'd0, out_rt}, {118'd0, e.rt});
        end
      end else if (!out_valid) begin
        check("idle_zero", {out_lane_valid, out_pc, out_insn[63:0] & 64'h0, out_rs, out_rt},
              {2'd0, 64'd0, 64'd0, 10'd0, 10'd0});
        check("idle_insn_zero", {64'd0, out_insn}, 128'd0);
      end
    end
    if (!rst || flush) begin
      expQ.delete();
    end else if (in_valid && in_ready) begin
      expQ.push_back(vecs[curIdx]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx, input logic st, input logic fl);
    in_valid      = v;
    curIdx        = idx;
    in_lane_valid = vecs[idx].lv;
    in_pc         = vecs[idx].pc;
    in_insn       = vecs[idx].insn;
    stall         = st;
    flush         = fl;
  endtask

  initial begin
    vecs[0] = '{2'b11, {32'h104, 32'h100}, {32'h8C2A0004, 32'h00851020}, {5'd1, 5'd4},  {5'd10, 5'd5}};
    vecs[1] = '{2'b11, {32'h10C, 32'h108}, {32'hAFBF0010, 32'h02328020}, {5'd29, 5'd17}, {5'd31, 5'd18}};
    vecs[2] = '{2'b11, {32'h204, 32'h200}, {32'h8FA40018, 32'h03E00008}, {5'd29, 5'd31}, {5'd4, 5'd0}};
    vecs[3] = '{2'b01, {32'h304, 32'h300}, {32'h8C2A0004, 32'h24420001}, {5'd0, 5'd2},  {5'd0, 5'd2}};
    vecs[4] = '{2'b00, {32'h404, 32'h400}, {32'h02328020, 32'h00851020}, {5'd0, 5'd0},  {5'd0, 5'd0}};
    vecs[5] = '{2'b11, {32'h504, 32'h500}, {32'h00851020, 32'h02328020}, {5'd4, 5'd17}, {5'd5, 5'd18}};
    vecs[6] = '{2'b11, {32'h604, 32'h600}, {32'h8C2A0004, 32'h8C2A0004}, {5'd1, 5'd1},  {5'd10, 5'd10}};
    errors = 0;
    checks = 0;
    monOn  = 1'b0;
    rst    = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    tick();
    tick();
    check("reset_out_valid", {127'd0, out_valid}, 128'd0);
    check("reset_in_ready", {127'd0, in_ready}, 128'd1);
    check("reset_out_pc", {64'd0, out_pc}, 128'd0);
    check("reset_perf", {64'd0, perf_stall_cnt, perf_flush_cnt}, 128'd0);
    rst   = 1'b1;
    monOn = 1'b1;

    // Streaming without stall, including the spec example bundle.
    drive(1'b1, 0, 1'b0, 1'b0); tick();
    check("stream_pc_v0", {64'd0, out_pc}, {64'd0, 32'h104, 32'h100});
    drive(1'b1, 1, 1'b0, 1'b0); tick();
    drive(1'b1, 2, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 1'b0, 1'b0); tick();
    tick();
    check("stream_drain_valid", {127'd0, out_valid}, 128'd0);

    // Three stall cycles: A=v3 held, B=v4 skidded, v5 waits for in_ready.
    drive(1'b1, 3, 1'b0, 1'b0); tick();
    drive(1'b1, 4, 1'b1, 1'b0); tick();
    check("stall_in_ready_low", {127'd0, in_ready}, 128'd0);
    check("stall_hold_a_pc", {64'd0, out_pc}, {64'd0, 32'h304, 32'h300});
    drive(1'b1, 5, 1'b1, 1'b0); tick();
    tick();
    check("stall_still_a", {64'd0, out_pc}, {64'd0, 32'h304, 32'h300});
    drive(1'b1, 5, 1'b0, 1'b0); tick();
    check("release_b_pc", {64'd0, out_pc}, {64'd0, 32'h404, 32'h400});
    check("release_in_ready", {127'd0, in_ready}, 128'd1);
    tick();
    drive(1'b0, 0, 1'b0, 1'b0); tick();
    tick();

    // Flush while FULL with a bundle offered: everything dropped.
    drive(1'b1, 0, 1'b0, 1'b0); tick();
    drive(1'b1, 1, 1'b1, 1'b0); tick();
    check("full_in_ready", {127'd0, in_ready}, 128'd0);
    drive(1'b1, 6, 1'b1, 1'b1); tick();
    check("flush_out_valid", {127'd0, out_valid}, 128'd0);
    check("flush_in_ready", {127'd0, in_ready}, 128'd1);
    drive(1'b1, 3, 1'b0, 1'b0); tick();
    check("post_flush_pc", {64'd0, out_pc}, {64'd0, 32'h304, 32'h300});
    drive(1'b0, 0, 1'b0, 1'b0); tick();

    // Flush and stall together: flush wins.
    drive(1'b1, 4, 1'b0, 1'b0); tick();
    drive(1'b1, 5, 1'b1, 1'b1); tick();
    check("flush_stall_valid", {127'd0, out_valid}, 128'd0);
    drive(1'b0, 0, 1'b0, 1'b0); tick();

`ifdef IFID_PERF_COUNTER_EN
    check("perf_stall", {96'd0, perf_stall_cnt}, 128'd4);
    check("perf_flush", {96'd0, perf_flush_cnt}, 128'd2);
`else
    check("perf_stall", {96'd0, perf_stall_cnt}, 128'd0);
    check("perf_flush", {96'd0, perf_flush_cnt}, 128'd0);
`endif

    // Reset mid-stream from FULL.
    drive(1'b1, 0, 1'b0, 1'b0); tick();
    drive(1'b1, 1, 1'b1, 1'b0); tick();
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0); tick();
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_outputs", {out_pc, out_insn}, 128'd0);
    check("midrst_perf", {64'd0, perf_stall_cnt, perf_flush_cnt}, 128'd0);
    rst = 1'b1;

    drive(1'b1, 2, 1'b0, 1'b0); tick();
    drive(1'b0, 0, 1'b0, 1'b0); tick();
    tick();
    check("queue_empty", 128'(expQ.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- Parametrised IF/ID pipeline register carrying LANES fetch slots (PC, instruction, per-lane valid) from fetch to decode.
- Adds a ready/valid handshake with a one-entry skid buffer, so a decode stall never drops a fetched bundle and in_ready is a registered signal.
- Flush from branch resolution kills both held bundles.
- Exports early RS/RT fields per lane for the hazard unit.

Parameters:
- LANES, 2, fetch slots per bundle (>=1)
- ADDR_WIDTH, 32, instruction address width
- INSN_WIDTH, 32, instruction width
- REG_NUM_WIDTH, 5, register-number field width
- RS_POS, 21, LSB position of RS field in instruction
- RT_POS, 16, LSB position of RT field in instruction

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- flush  in  1  control hazard; discard all held and incoming bundles
- stall  in  1  data hazard; decode does not accept this cycle (downstream ready = !stall)
- in_valid  in  1  fetch bundle valid
- in_ready  out  1  block can accept a bundle this cycle (registered)
- in_lane_valid  in  LANES  per-slot valid within bundle
- in_pc  in  LANES*ADDR_WIDTH  slot PCs, lane 0 in LSBs
- in_insn  in  LANES*INSN_WIDTH  slot instructions, lane 0 in LSBs
- out_valid  out  1  bundle presented to decode
- out_lane_valid  out  LANES  per-slot valid, all 0 when !out_valid
- out_pc  out  LANES*ADDR_WIDTH  held PCs
- out_insn  out  LANES*INSN_WIDTH  held instructions
- out_rs  out  LANES*REG_NUM_WIDTH  RS field per lane, combinational from out_insn
- out_rt  out  LANES*REG_NUM_WIDTH  RT field per lane, combinational from out_insn
- perf_stall_cnt  out  32  stall cycles with out_valid (PERF_COUNTER_EN only)
- perf_flush_cnt  out  32  flush events (PERF_COUNTER_EN only)

Behaviour:
- Storage: main register (drives outputs) and skid register, each holding valid + lane_valid + pcs + insns.
- Reset (rst=0 at posedge): main and skid valid=0, all payload 0, in_ready=1, counters 0.
- Outputs out_pc/out_insn/out_lane_valid are forced to 0 whenever main is invalid.
- out_rs/out_rt are 0 for lanes whose out_lane_valid=0.
- Accept into the block: in_valid && in_ready.
- Priority per cycle: reset > flush > stall > advance.
- Flush: main.valid<=0, skid.valid<=0, in_ready<=1. An incoming bundle that cycle is dropped even if accepted.
- Stall (flush=0): main holds. An accepted bundle goes into skid (skid empty is guaranteed by in_ready). in_ready<=0 next cycle once skid is full.
- Advance (flush=0, stall=0):
  - If skid full: main<=skid, skid.valid<=0, in_ready<=1.
  - Else main<=accepted input, or main.valid<=0 if no accept.
  - Latency input->output: 1 cycle when no stall.
- Bundle order is strictly preserved; no bundle is lost or duplicated across any stall pattern.
- States: EMPTY (main invalid), HOLD (main valid, skid empty), FULL (both valid; in_ready=0).
  - EMPTY->HOLD on accept.
  - HOLD->FULL on stall && accept.
  - FULL->HOLD on !stall.
  - Any->EMPTY on flush or reset.
- A bundle with in_valid=1 and in_lane_valid=0 is accepted and carried unchanged.

Optional Feature:
- Macro IFID_PERF_COUNTER_EN.
- Defined: perf_stall_cnt increments each cycle with stall && main.valid && !flush. perf_flush_cnt increments each cycle flush=1. Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports tie to 0 and no counter flops are generated.

Decomposition:
- Shared package holds bundle typedef (valid, lane_valid, pc array, insn array), ADDR/INSN/REG_NUM width constants, RS_POS/RT_POS.
- One sub-module, ifid_bundle_reg: a loadable/clearable bundle register instanced twice (main, skid).
- Field extraction is a generate loop in the top module.

Test Plan:
- Reset mid-stream: FULL state, drop rst for 1 cycle -> out_valid=0, in_ready=1, outputs 0 next cycle.
- Streaming, LANES=2: in_pc {0x104,0x100}, insn {0x8C2A0004,0x00851020} with no stall -> next cycle out_pc matches; out_rs lane0=4, out_rt lane0=5; out_rs lane1=1, out_rt lane1=10.
- Stall 3 cycles while upstream presents bundles A, B:
  - A held on outputs; B captured in skid; in_ready=0 from 2nd stall cycle.
  - On release, B appears the following cycle, then in_ready=1; no loss or duplication.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, skid empty, in_ready=1, incoming bundle dropped.
- Flush and stall same cycle -> flush wins: out_valid=0 next cycle.
- IFID_PERF_COUNTER_EN: 4 stall cycles with valid main, 2 flushes -> perf_stall_cnt=4, perf_flush_cnt=2. Without macro both read 0.
